// File: rtl/array_loader_n_m_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel array loader.
package array_loader_n_m_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   // Bits needed to index slots 0..last, never less than one.
   function automatic int unsigned idx_width(input int unsigned last);
      return (last < 1) ? 1 : $clog2(last + 1);
   endfunction

endpackage

// File: rtl/array_loader_n_m_onehot_dec.sv
// One-hot slot write-enable decoder: asserts bit sel when en is high.
module onehot_dec_n #(
   parameter int unsigned n = 16,
   parameter int unsigned w = 4
) (
   input  logic [w-1:0] sel,
   input  logic         en,
   output logic [n-1:0] we_c
);

   always_comb begin
      we_c = '0;
      for (int unsigned i = 0; i < n; i++) begin
         if (en && (sel == w'(i))) we_c[i] = 1'b1;
      end
   end

endmodule

// File: rtl/array_loader_n_m.sv
// Fills an (m+1)-entry, n-bit register array from a valid/ready word stream
// and pulses done_o once the last slot has been written.
module array_loader_n_m
   import array_loader_n_m_pkg::*;
#(
   parameter int unsigned n     = 4,
   parameter int unsigned m     = 15,
   parameter int unsigned value = 0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          clear_i,
   input  logic                          start_i,
   input  logic [n-1:0]                  data_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   output logic [n-1:0]                  arr_o [0:m],
   output logic [idx_width(m)-1:0]       idx_o,
   output logic                          busy_o,
   output logic                          done_o
);

   localparam int unsigned IW       = idx_width(m);
   localparam logic [n-1:0] CLR_WORD = n'(value);

   state_t        state;
   logic          hs;
   logic [m:0]    we;

   // ready_o is a registered state decode, so the handshake has no valid->ready path.
   assign hs = valid_i && ready_o;

   onehot_dec_n #(
      .n (m + 1),
      .w (IW)
   ) u_dec (
      .sel  (idx_o),
      .en   (hs),
      .we_c (we)
   );

   // Control FSM with registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         idx_o   <= '0;
         ready_o <= 1'b0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (clear_i) begin
            state   <= IDLE;
            idx_o   <= '0;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_i) begin
                     state   <= LOAD;
                     idx_o   <= '0;
                     ready_o <= 1'b1;
                     busy_o  <= 1'b1;
                  end
               end
               LOAD: begin
                  if (hs) begin
                     if (idx_o == IW'(m)) begin
                        state   <= IDLE;
                        idx_o   <= '0;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                     end else begin
                        idx_o <= idx_o + IW'(1);
                     end
                  end
               end
               default: begin
                  state   <= IDLE;
                  ready_o <= 1'b0;
                  busy_o  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Per-slot enabled storage; clear discards any same-cycle write.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i <= m; i++) arr_o[i] <= CLR_WORD;
      end else if (clear_i) begin
         for (int unsigned i = 0; i <= m; i++) arr_o[i] <= CLR_WORD;
      end else begin
         for (int unsigned i = 0; i <= m; i++) begin
            if (we[i]) arr_o[i] <= data_i;
         end
      end
   end

endmodule

// File: tb/tb_array_loader_n_m.sv
// Directed self-checking bench for array_loader_n_m with n=4, m=3, value=5.
module tb_array_loader_n_m;

   localparam int unsigned N = 4;
   localparam int unsigned M = 3;
   localparam int unsigned V = 5;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         clear_i = 1'b0;
   logic         start_i = 1'b0;
   logic [N-1:0] data_i = '0;
   logic         valid_i = 1'b0;
   logic         ready_o;
   logic [N-1:0] arr_o [0:M];
   logic [1:0]   idx_o;
   logic         busy_o;
   logic         done_o;

   int tests = 0;
   int failed = 0;

   array_loader_n_m #(.n(N), .m(M), .value(V)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .start_i (start_i),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .arr_o   (arr_o),
      .idx_o   (idx_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] arr_word();
      return 32'({arr_o[0], arr_o[1], arr_o[2], arr_o[3]});
   endfunction

   // Advance one rising edge and settle at the following falling edge.
   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      // Asynchronous reset between edges.
      #2 rst_i = 1'b1;
      #1;
      check("rst_arr", arr_word(), 32'h5555);
      check("rst_ready", 32'(ready_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_idx", 32'(idx_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      tick();
      rst_i = 1'b0;
      tick();

      // Back-to-back load, then restart in the done cycle.
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("b2b_busy", 32'(busy_o), 32'd1);
      for (int k = 0; k < 4; k++) begin
         check("b2b_ready", 32'(ready_o), 32'd1);
         check("b2b_idx", 32'(idx_o), 32'(k));
         check("b2b_done_lo", 32'(done_o), 32'd0);
         valid_i = 1'b1;
         data_i  = 4'(k + 1);
         tick();
      end
      valid_i = 1'b0;
      check("b2b_done", 32'(done_o), 32'd1);
      check("b2b_ready_lo", 32'(ready_o), 32'd0);
      check("b2b_arr", arr_word(), 32'h1234);
      check("b2b_idx_wrap", 32'(idx_o), 32'd0);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("b2b_done_pulse", 32'(done_o), 32'd0);
      check("restart_ready", 32'(ready_o), 32'd1);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check("clr_arr", arr_word(), 32'h5555);

      // Load with a bubble on the second cycle.
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      valid_i = 1'b1; data_i = 4'h1;
      tick();
      valid_i = 1'b0;
      check("bub_idx1", 32'(idx_o), 32'd1);
      tick();
      check("bub_idx_hold", 32'(idx_o), 32'd1);
      check("bub_arr_hold", arr_word(), 32'h1555);
      for (int k = 2; k <= 4; k++) begin
         check("bub_done_lo", 32'(done_o), 32'd0);
         valid_i = 1'b1;
         data_i  = 4'(k);
         tick();
      end
      valid_i = 1'b0;
      check("bub_done", 32'(done_o), 32'd1);
      check("bub_arr", arr_word(), 32'h1234);
      tick();

      // Clear mid-load discards the coincident word.
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      valid_i = 1'b1; data_i = 4'h9;
      tick();
      data_i = 4'h8;
      tick();
      check("clr_partial", arr_word(), 32'h9834);
      check("clr_idx2", 32'(idx_o), 32'd2);
      data_i  = 4'h7;
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      valid_i = 1'b0;
      check("clr_mid_arr", arr_word(), 32'h5555);
      check("clr_mid_idx", 32'(idx_o), 32'd0);
      check("clr_mid_busy", 32'(busy_o), 32'd0);
      check("clr_mid_ready", 32'(ready_o), 32'd0);
      check("clr_mid_done", 32'(done_o), 32'd0);
      tick();
      check("clr_mid_done2", 32'(done_o), 32'd0);

      // start_i ignored in LOAD; clear_i beats start_i in IDLE.
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      valid_i = 1'b1; data_i = 4'h1;
      tick();
      valid_i = 1'b0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("ld_start_idx", 32'(idx_o), 32'd1);
      check("ld_start_busy", 32'(busy_o), 32'd1);
      clear_i = 1'b1;
      tick();
      start_i = 1'b1;
      tick();
      clear_i = 1'b0;
      start_i = 1'b0;
      check("clr_vs_start_busy", 32'(busy_o), 32'd0);
      check("clr_vs_start_ready", 32'(ready_o), 32'd0);
      tick();
      check("clr_vs_start_idle", 32'(busy_o), 32'd0);

      // Reset pulse mid-load, then a fresh full load.
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      valid_i = 1'b1; data_i = 4'h3;
      tick();
      data_i = 4'h6;
      tick();
      valid_i = 1'b0;
      check("rml_partial", arr_word(), 32'h3655);
      #2 rst_i = 1'b1;
      #1;
      check("rml_arr", arr_word(), 32'h5555);
      check("rml_busy", 32'(busy_o), 32'd0);
      #1 rst_i = 1'b0;
      tick();
      check("rml_done", 32'(done_o), 32'd0);
      check("rml_idle", 32'(ready_o), 32'd0);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         valid_i = 1'b1;
         data_i  = 4'(4'hA + k);
         tick();
      end
      valid_i = 1'b0;
      check("fresh_done", 32'(done_o), 32'd1);
      check("fresh_arr", arr_word(), 32'hABCD);
      tick();
      check("fresh_done_lo", 32'(done_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
